mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
Sequencer for one MAC accumulator unit. It computes one dot product of length VEC_LEN per start command:
- streams operand pairs from a dual-output operand buffer (1-cycle read latency) into the MAC;
- drives the MAC enable and clear strobes;
- captures the final accumulator value and presents it on a valid/ready result interface.

It sits between the control/host logic and the MAC datapath.

Parameters:
DATA_WIDTH, 8, operand width; MAC accumulator/result width is 3*DATA_WIDTH
VEC_LEN, 8, operand pairs per dot product; legal range 1..2**ADDR_WIDTH
ADDR_WIDTH, 3, operand buffer address width

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a dot product; accepted only in IDLE
busy  output  1  high in every state except IDLE
rd_en  output  1  operand buffer read strobe
rd_addr  output  ADDR_WIDTH  operand buffer read address
a_rdata  input  DATA_WIDTH  A operand, valid the cycle after rd_en
b_rdata  input  DATA_WIDTH  B operand, valid the cycle after rd_en
mac_clr  output  1  MAC synchronous clear
mac_en  output  1  MAC accumulate enable
mac_a  output  DATA_WIDTH  MAC A input
mac_b  output  DATA_WIDTH  MAC B input
mac_cout  input  3*DATA_WIDTH  MAC accumulator value (registered in MAC)
result  output  3*DATA_WIDTH  captured dot product
result_valid  output  1  result available
result_ready  input  1  consumer accepts result

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values:
  - state = IDLE;
  - rd_en, mac_clr, mac_en, busy, result_valid = 0;
  - rd_addr = 0; result = 0.
  - Reset mid-operation aborts immediately. No partial result is ever flagged valid.
- mac_a/mac_b are combinational pass-throughs of a_rdata/b_rdata.
- mac_en is rd_en delayed by one register stage. Only mac_en is pipelined.
- States:
  - IDLE: busy=0. If start=1, go to CLR.
  - CLR: mac_clr=1 for exactly one cycle. Go to STREAM. Clears rd_addr counter to 0.
  - STREAM: rd_en=1; rd_addr increments 0..VEC_LEN-1, one per cycle. Leave after the cycle with rd_addr=VEC_LEN-1 and go to DRAIN. rd_addr does not wrap past VEC_LEN-1.
  - DRAIN: one cycle; rd_en=0; mac_en=1 for the final pair. Go to SETTLE.
  - SETTLE: mac_cout now holds the final sum. result <= mac_cout at the edge. Go to DONE.
  - DONE: result_valid=1; result held stable. On result_ready=1, go to IDLE (result_valid drops the next cycle). Otherwise stay.
- Timing:
  - mac_en is high for exactly VEC_LEN consecutive cycles per run.
  - mac_clr is never high in the same cycle as mac_en.
  - Latency: start sampled in cycle 0 → result_valid first high in cycle VEC_LEN+4.
  - Minimum start-to-start spacing: VEC_LEN+5 cycles with result_ready tied high.
- start while busy (any non-IDLE state, including DONE) is ignored, not queued.
- Arithmetic: the controller performs none. Accumulator overflow wraps modulo 2**(3*DATA_WIDTH) inside the MAC and is not flagged.
- Every run begins with mac_clr, so a run never includes the previous run's sum.
- result retains its last captured value after handshake until the next SETTLE or reset.

Test Plan:
- Basic: buffer A[i]=B[i]=i+1 (i=0..7), pulse start → 8 consecutive mac_en cycles, rd_addr 0..7, result_valid at cycle 12, result=204 (0x0000CC).
- Max operands: all A=B=0xFF → result=520200 (0x07F008); mac_clr high exactly 1 cycle before STREAM.
- Backpressure: result_ready low 5 cycles in DONE, start pulsed meanwhile → result_valid and result stable, busy=1, no new run; on result_ready=1 → IDLE next cycle.
- Back-to-back: run A=B=1 (result 8) then A=2,B=3 (result 48) → second result 48, not 56; mac_clr precedes each run.
- Reset mid-STREAM: assert rst_n=0 at rd_addr=3 → outputs immediately at reset values; after release, start → correct full result, no spurious result_valid.
- VEC_LEN=1 build: A=7,B=9 → single mac_en cycle, result=63, result_valid at cycle 5.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for one MAC accumulator.
// A start command triggers one dot product of VEC_LEN operand pairs. Each run
// clears the MAC, streams the operand buffer into it, lets the accumulator
// settle, captures the sum, and offers it on a valid/ready result port.
// All control outputs are registered. mac_a/mac_b are direct pass-throughs
// from the operand buffer.
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   a_rdata,
    input  logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic [DATA_WIDTH-1:0]   mac_a,
    output logic [DATA_WIDTH-1:0]   mac_b,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic [3*DATA_WIDTH-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready
);

    localparam int                    RES_W     = 3 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VEC_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_SETTLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic                    rd_en_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_d;
    logic                    mac_clr_q;
    logic                    mac_en_q;
    logic [RES_W-1:0]        result_q;
    logic                    result_valid_q;

    // Next read address: count up through the vector and stop on the last pair.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (rd_addr_q != LAST_ADDR) begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
        end else begin
            rd_addr_d = rd_addr_q;
        end
    end

    // Sequencer FSM; every control output is set for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            mac_clr_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            mac_clr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_CLR;
                        busy_q    <= 1'b1;
                        mac_clr_q <= 1'b1;
                    end
                end
                S_CLR: begin
                    state_q   <= S_STREAM;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= '0;
                end
                S_STREAM: begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_q <= S_DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        rd_addr_q <= rd_addr_d;
                    end
                end
                S_DRAIN: begin
                    // Final pair is being accumulated this cycle.
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    // Accumulator now holds the complete sum.
                    state_q        <= S_DONE;
                    result_q       <= mac_cout;
                    result_valid_q <= 1'b1;
                end
                S_DONE: begin
                    if (result_ready) begin
                        state_q        <= S_IDLE;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= S_IDLE;
                    busy_q         <= 1'b0;
                    rd_en_q        <= 1'b0;
                    result_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // MAC enable follows the read strobe by the buffer's one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_en_q <= 1'b0;
        end else begin
            mac_en_q <= rd_en_q;
        end
    end

    assign busy         = busy_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign mac_clr      = mac_clr_q;
    assign mac_en       = mac_en_q;
    assign mac_a        = a_rdata;
    assign mac_b        = b_rdata;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: drives mac_seq_ctrl with an operand buffer and MAC model,
// compares every cycle against a timeline model of a run, and adds directed
// scenarios with hand-computed results.
module tb_mac_seq_ctrl;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int RW = 3 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          result_ready = 1'b0;
    logic          busy, rd_en, mac_clr, mac_en, result_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] a_rdata = '0;
    logic [DW-1:0] b_rdata = '0;
    logic [DW-1:0] mac_a, mac_b;
    logic [RW-1:0] mac_cout = '0;
    logic [RW-1:0] result;

    // Second instance with a single-pair vector
    logic          start1 = 1'b0;
    logic          result_ready1 = 1'b1;
    logic          busy1, rd_en1, mac_clr1, mac_en1, result_valid1;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] a_rdata1 = '0;
    logic [DW-1:0] b_rdata1 = '0;
    logic [DW-1:0] mac_a1, mac_b1;
    logic [RW-1:0] mac_cout1 = '0;
    logic [RW-1:0] result1;

    logic [DW-1:0] mem_a [0:N-1];
    logic [DW-1:0] mem_b [0:N-1];
    logic [DW-1:0] mem1_a = 8'd7;
    logic [DW-1:0] mem1_b = 8'd9;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;
    int en1_cnt = 0;

    mac_seq_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(N), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .mac_cout(mac_cout), .result(result), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    mac_seq_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(1), .ADDR_WIDTH(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .a_rdata(a_rdata1), .b_rdata(b_rdata1),
        .mac_clr(mac_clr1), .mac_en(mac_en1), .mac_a(mac_a1), .mac_b(mac_b1),
        .mac_cout(mac_cout1), .result(result1), .result_valid(result_valid1),
        .result_ready(result_ready1)
    );

    always #5 clk = ~clk;

    // Operand buffers with one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= mem_a[rd_addr];
            b_rdata <= mem_b[rd_addr];
        end
        if (rd_en1) begin
            a_rdata1 <= (rd_addr1 == 3'd0) ? mem1_a : 8'hEE;
            b_rdata1 <= (rd_addr1 == 3'd0) ? mem1_b : 8'hEE;
        end
    end

    // MAC datapaths (registered accumulators, modulo 2**RW)
    always @(posedge clk) begin
        if (mac_clr)     mac_cout <= '0;
        else if (mac_en) mac_cout <= mac_cout + RW'(mac_a) * RW'(mac_b);
        if (mac_clr1)     mac_cout1 <= '0;
        else if (mac_en1) mac_cout1 <= mac_cout1 + RW'(mac_a1) * RW'(mac_b1);
        if (mac_en1)      en1_cnt <= en1_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act_v, exp_v, $time);
        end
    endtask

    // ---------------- reference model: a run as a timeline ----------------
    // m_t = cycles since the cycle in which start was accepted (that cycle is 0).
    bit            m_active = 1'b0;
    bit            m_ran = 1'b0;
    int            m_t = 0;
    logic [RW-1:0] m_sum = '0;
    logic [RW-1:0] m_result = '0;

    function automatic logic [RW-1:0] dot();
        logic [RW-1:0] s = '0;
        for (int i = 0; i < N; i++) s = s + RW'(mem_a[i]) * RW'(mem_b[i]);
        return s;
    endfunction

    function automatic logic [31:0] exp_addr();
        if (m_active && m_t >= 2 && m_t <= N + 1) return 32'(m_t - 2);
        else if (m_active && m_t >= N + 2)        return 32'(N - 1);
        else if (m_ran)                           return 32'(N - 1);
        else                                      return 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_ran    <= 1'b0;
            m_result <= '0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_t      <= 1;
                m_sum    <= dot();
            end
        end else if (m_t < N + 4) begin
            m_t <= m_t + 1;
            if (m_t == N + 1) m_ran <= 1'b1;
            if (m_t == N + 3) m_result <= m_sum;
        end else if (result_ready) begin
            m_active <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("busy",         32'(busy),         32'(m_active));
            check("mac_clr",      32'(mac_clr),      32'(m_active && m_t == 1));
            check("rd_en",        32'(rd_en),        32'(m_active && m_t >= 2 && m_t <= N + 1));
            check("mac_en",       32'(mac_en),       32'(m_active && m_t >= 3 && m_t <= N + 2));
            check("result_valid", 32'(result_valid), 32'(m_active && m_t == N + 4));
            check("result",       32'(result),       32'(m_result));
            check("mac_a",        32'(mac_a),        32'(a_rdata));
            check("mac_b",        32'(mac_b),        32'(b_rdata));
            if (!(m_active && m_t == 1)) check("rd_addr", 32'(rd_addr), exp_addr());
        end
    end

    // ---------------- directed helpers ----------------
    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: begin mem_a[i] = DW'(i + 1); mem_b[i] = DW'(i + 1); end
                1: begin mem_a[i] = 8'hFF;      mem_b[i] = 8'hFF;      end
                2: begin mem_a[i] = 8'd1;       mem_b[i] = 8'd1;       end
                default: begin mem_a[i] = 8'd2; mem_b[i] = 8'd3;       end
            endcase
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Start a run and report the cycle of the first result_valid
    task automatic measure(input string nm, input int exp_lat, input logic [RW-1:0] exp_res);
        int lat = 1;
        pulse_start();
        while (!result_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nm, "_result"},  32'(result), 32'(exp_res));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int lat;
        int base;
        int idx;
        fill(0);

        // Reset values
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        #2;
        check("rst_busy",    32'(busy),         32'd0);
        check("rst_rd_en",   32'(rd_en),        32'd0);
        check("rst_valid",   32'(result_valid), 32'd0);
        check("rst_result",  32'(result),       32'd0);
        check("rst_rd_addr", 32'(rd_addr),      32'd0);
        #4 rst_n = 1'b1;

        // Basic: A=B=i+1 -> 204, valid in cycle 12
        result_ready = 1'b1;
        wait_idle();
        measure("basic", 12, 24'd204);

        // Max operands -> 520200
        wait_idle();
        fill(1);
        measure("max", 12, 24'd520200);

        // Backpressure with ignored start pulses in DONE
        wait_idle();
        fill(0);
        result_ready = 1'b0;
        pulse_start();
        k = 0;
        while (!result_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            @(posedge clk); #1;
            check("bp_valid",  32'(result_valid), 32'd1);
            check("bp_busy",   32'(busy),         32'd1);
            check("bp_result", 32'(result),       32'd204);
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_busy",  32'(busy),         32'd0);
        check("bp_idle_valid", 32'(result_valid), 32'd0);

        // Back-to-back runs must not carry the previous sum
        fill(2);
        measure("b2b_first", 12, 24'd8);
        fill(3);
        measure("b2b_second", 12, 24'd48);

        // Reset in the middle of streaming
        wait_idle();
        fill(0);
        pulse_start();
        k = 0;
        while (!(rd_en && rd_addr == 3'd3) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",    32'(busy),         32'd0);
        check("mid_rst_rd_en",   32'(rd_en),        32'd0);
        check("mid_rst_mac_en",  32'(mac_en),       32'd0);
        check("mid_rst_mac_clr", 32'(mac_clr),      32'd0);
        check("mid_rst_valid",   32'(result_valid), 32'd0);
        check("mid_rst_rd_addr", 32'(rd_addr),      32'd0);
        check("mid_rst_result",  32'(result),       32'd0);
        #4 rst_n = 1'b1;
        measure("after_reset", 12, 24'd204);

        // Single-pair build: 7*9 = 63, valid in cycle 5
        base = en1_cnt;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        lat = 1;
        while (!result_valid1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("vec1_latency", 32'(lat),              32'd5);
        check("vec1_result",  32'(result1),          32'd63);
        check("vec1_mac_en",  32'(en1_cnt - base),   32'd1);

        // Randomized traffic checked by the per-cycle model
        wait_idle();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            result_ready = ($urandom_range(0, 2) != 0);
            start = ($urandom_range(0, 3) == 0);
            if (!m_active && !start) begin
                idx = $urandom_range(0, N - 1);
                mem_a[idx] = DW'($urandom_range(0, 255));
                mem_b[idx] = DW'($urandom_range(0, 255));
            end
        end
        start = 1'b0;
        result_ready = 1'b1;
        wait_idle();
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
